// File: rtl/byte_inc_pipe.sv
// Purpose : streams N words from the Avalon-MM read master, adds inc to each enabled byte, writes them back out.
// Latency : first read issued the cycle after run_i is accepted; a word is written the cycle after its readdata arrives.
// Backpress: reads stop when outstanding + buffered words reach FIFO_DEPTH; writes hold stable under amm_wr_waitrequest_i.
//
// Ports:
//   clk_i, arst_n_i                    clock, asynchronous active-low reset
//   base_addr_i, length_i, inc_i       job parameters (word address, byte count, per-byte increment), taken with run_i
//   run_i / waitrequest_o              start pulse / busy flag
//   amm_rd_*                           Avalon-MM read master (pipelined, readdatavalid)
//   amm_wr_*                           Avalon-MM write master
module byte_inc_pipe #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 10,
   parameter int BYTE_CNT   = DATA_WIDTH / 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk_i,
   input  logic                  arst_n_i,
   input  logic [ADDR_WIDTH-1:0] base_addr_i,
   input  logic [ADDR_WIDTH-1:0] length_i,
   input  logic [7:0]            inc_i,
   input  logic                  run_i,
   output logic                  waitrequest_o,
   output logic [ADDR_WIDTH-1:0] amm_rd_address_o,
   output logic                  amm_rd_read_o,
   input  logic [DATA_WIDTH-1:0] amm_rd_readdata_i,
   input  logic                  amm_rd_readdatavalid_i,
   input  logic                  amm_rd_waitrequest_i,
   output logic [ADDR_WIDTH-1:0] amm_wr_address_o,
   output logic                  amm_wr_write_o,
   output logic [DATA_WIDTH-1:0] amm_wr_writedata_o,
   output logic [BYTE_CNT-1:0]   amm_wr_byteenable_o,
   input  logic                  amm_wr_waitrequest_i
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACTIVE = 2'd1;
   localparam logic [1:0] ST_DRAIN  = 2'd2;

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   // control state
   logic [1:0]            r_state;
   logic                  r_run_en;
   logic                  r_waitreq;
   logic [ADDR_WIDTH-1:0] r_base;
   logic [ADDR_WIDTH-1:0] r_last_idx;
   logic [ADDR_WIDTH-1:0] r_rd_idx;
   logic [ADDR_WIDTH-1:0] r_wr_idx;
   logic [7:0]            r_inc;
   logic [BYTE_CNT-1:0]   r_last_be;
   logic [CW-1:0]         r_outst;

   // read-data buffer
   logic [DATA_WIDTH-1:0] r_fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]         r_fifo_wptr;
   logic [PW-1:0]         r_fifo_rptr;
   logic [CW-1:0]         r_fifo_cnt;

   logic [ADDR_WIDTH-1:0] w_last_idx;
   logic [ADDR_WIDTH-1:0] w_rem;
   logic [BYTE_CNT-1:0]   w_last_be;
   logic                  w_start;
   logic                  w_room_ok;
   logic                  w_rd_req;
   logic                  w_rd_acc;
   logic                  w_rd_last;
   logic                  w_push;
   logic                  w_fifo_vld;
   logic [DATA_WIDTH-1:0] w_fifo_head;
   logic                  w_wr_req;
   logic                  w_wr_acc;
   logic                  w_wr_last;
   logic [BYTE_CNT-1:0]   w_be;
   logic [DATA_WIDTH-1:0] w_wdata;

   // Index of the last word is floor((len-1)/BYTE_CNT); only used when len != 0.
   assign w_last_idx = (length_i - 1'b1) / ADDR_WIDTH'(BYTE_CNT);
   assign w_rem      = length_i % ADDR_WIDTH'(BYTE_CNT);
   assign w_last_be  = (w_rem == '0) ? {BYTE_CNT{1'b1}} : ~({BYTE_CNT{1'b1}} << w_rem);

   // r_run_en blocks acceptance on the first edge after reset release, so a
   // late-arriving deassertion can never race a start into the FSM.
   assign w_start = (r_state == ST_IDLE) && run_i && (length_i != '0) && r_run_en;

   // The sum below cannot grow while a read is stalled (returns only move a
   // word from outstanding into the buffer, pops only shrink it), so the read
   // request stays asserted until accepted.
   assign w_room_ok = ({1'b0, r_outst} + {1'b0, r_fifo_cnt}) < (CW + 1)'(FIFO_DEPTH);
   assign w_rd_req  = (r_state == ST_ACTIVE) && w_room_ok;
   assign w_rd_acc  = w_rd_req && !amm_rd_waitrequest_i;
   assign w_rd_last = (r_rd_idx == r_last_idx);

   // Returns with nothing outstanding (stale after reset, or spurious) are dropped.
   assign w_push = amm_rd_readdatavalid_i && (r_state != ST_IDLE) && (r_outst != '0);

   assign w_fifo_vld  = (r_fifo_cnt != '0);
   assign w_fifo_head = r_fifo_mem[r_fifo_rptr];

   assign w_wr_req  = (r_state != ST_IDLE) && w_fifo_vld;
   assign w_wr_acc  = w_wr_req && !amm_wr_waitrequest_i;
   assign w_wr_last = (r_wr_idx == r_last_idx);
   assign w_be      = w_wr_last ? r_last_be : {BYTE_CNT{1'b1}};

   always_comb begin
      w_wdata = w_fifo_head;
      for (int b = 0; b < BYTE_CNT; b++) begin
         if (w_be[b]) begin
            w_wdata[8*b +: 8] = w_fifo_head[8*b +: 8] + r_inc;
         end
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_run_en <= 1'b0;
      end else begin
         r_run_en <= 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_state    <= ST_IDLE;
         r_waitreq  <= 1'b0;
         r_base     <= '0;
         r_last_idx <= '0;
         r_inc      <= '0;
         r_last_be  <= '0;
         r_rd_idx   <= '0;
         r_wr_idx   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_state    <= ST_ACTIVE;
                  r_waitreq  <= 1'b1;
                  r_base     <= base_addr_i;
                  r_last_idx <= w_last_idx;
                  r_inc      <= inc_i;
                  r_last_be  <= w_last_be;
                  r_rd_idx   <= '0;
                  r_wr_idx   <= '0;
               end
            end
            ST_ACTIVE: begin
               if (w_rd_acc && w_rd_last) begin
                  r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (w_wr_acc && w_wr_last) begin
                  r_state   <= ST_IDLE;
                  r_waitreq <= 1'b0;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_waitreq <= 1'b0;
            end
         endcase
         // Neither acceptance can happen in IDLE, so these never collide with the start load.
         if (w_rd_acc) begin
            r_rd_idx <= r_rd_idx + 1'b1;
         end
         if (w_wr_acc) begin
            r_wr_idx <= r_wr_idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_outst <= '0;
      end else begin
         case ({w_rd_acc, w_push})
            2'b10:   r_outst <= r_outst + 1'b1;
            2'b01:   r_outst <= r_outst - 1'b1;
            default: r_outst <= r_outst;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_fifo_wptr <= '0;
         r_fifo_rptr <= '0;
         r_fifo_cnt  <= '0;
      end else begin
         if (w_push) begin
            r_fifo_wptr <= r_fifo_wptr + 1'b1;
         end
         if (w_wr_acc) begin
            r_fifo_rptr <= r_fifo_rptr + 1'b1;
         end
         case ({w_push, w_wr_acc})
            2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
            2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
            default: r_fifo_cnt <= r_fifo_cnt;
         endcase
      end
   end

   // Storage needs no reset: the count alone defines what is valid.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_fifo_mem[r_fifo_wptr] <= amm_rd_readdata_i;
      end
   end

   assign waitrequest_o       = r_waitreq;
   assign amm_rd_read_o       = w_rd_req;
   assign amm_rd_address_o    = r_base + r_rd_idx;
   assign amm_wr_write_o      = w_wr_req;
   assign amm_wr_address_o    = r_base + r_wr_idx;
   // Gated so unwritten buffer contents never reach the bus.
   assign amm_wr_writedata_o  = w_wr_req ? w_wdata : '0;
   assign amm_wr_byteenable_o = w_wr_req ? w_be : '0;

endmodule

// File: tb/tb_byte_inc_pipe.sv
module tb_byte_inc_pipe;

   localparam int DW = 64;
   localparam int AW = 10;
   localparam int BC = 8;
   localparam int FD = 4;

   logic          clk = 1'b0;
   always #5 clk = ~clk;

   logic          arst_n = 1'b0;
   logic [AW-1:0] base = '0;
   logic [AW-1:0] len = '0;
   logic [7:0]    inc = '0;
   logic          run = 1'b0;
   logic          waitreq;
   logic [AW-1:0] rd_addr;
   logic          rd_read;
   logic [DW-1:0] rdata = '0;
   logic          rdv = 1'b0;
   logic          rd_wait = 1'b0;
   logic [AW-1:0] wr_addr;
   logic          wr_write;
   logic [DW-1:0] wr_data;
   logic [BC-1:0] wr_be;
   logic          wr_wait = 1'b0;

   byte_inc_pipe #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_CNT(BC), .FIFO_DEPTH(FD)
   ) dut (
      .clk_i(clk), .arst_n_i(arst_n),
      .base_addr_i(base), .length_i(len), .inc_i(inc), .run_i(run),
      .waitrequest_o(waitreq),
      .amm_rd_address_o(rd_addr), .amm_rd_read_o(rd_read),
      .amm_rd_readdata_i(rdata), .amm_rd_readdatavalid_i(rdv),
      .amm_rd_waitrequest_i(rd_wait),
      .amm_wr_address_o(wr_addr), .amm_wr_write_o(wr_write),
      .amm_wr_writedata_o(wr_data), .amm_wr_byteenable_o(wr_be),
      .amm_wr_waitrequest_i(wr_wait)
   );

   // ---------------- memory / slave model ----------------
   logic [DW-1:0] mem [0:1023];

   typedef struct { logic [AW-1:0] addr; int due; } rsp_t;
   typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic [BC-1:0] be; } wr_t;

   rsp_t          rsp_q[$];
   logic [AW-1:0] rd_log[$];
   wr_t           wr_log[$];
   int cyc = 0;
   int rd_lat = 1;
   bit rd_st = 1'b0;
   bit wr_st = 1'b0;
   int outst = 0;
   int max_outst = 0;
   int rd_req_cyc = 0;
   int wr_req_cyc = 0;

   // Inputs for the coming cycle are set on the falling edge; DUT commands
   // (which depend only on DUT registers) are observed at the same point.
   always @(negedge clk) begin
      rsp_t r;
      cyc++;
      rd_wait = rd_st && (cyc % 3 == 0);
      wr_wait = wr_st && ((cyc / 2) % 2 == 0);
      if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
         r = rsp_q.pop_front();
         rdv = 1'b1;
         rdata = mem[r.addr];
         outst--;
      end else begin
         rdv = 1'b0;
         rdata = '0;
      end
      if (rd_read) rd_req_cyc++;
      if (rd_read && !rd_wait) begin
         rd_log.push_back(rd_addr);
         rsp_q.push_back('{rd_addr, cyc + rd_lat});
         outst++;
         if (outst > max_outst) max_outst = outst;
      end
      if (wr_write) wr_req_cyc++;
      if (wr_write && !wr_wait) wr_log.push_back('{wr_addr, wr_data, wr_be});
   end

   // ---------------- checking helpers ----------------
   int total = 0;
   int bad = 0;

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] expect_data(input logic [DW-1:0] src, input logic [BC-1:0] be,
                                                 input logic [7:0] add);
      logic [DW-1:0] r;
      r = src;
      for (int i = 0; i < BC; i++) begin
         if (be[i]) r[8*i +: 8] = src[8*i +: 8] + add;
      end
      return r;
   endfunction

   task automatic start_op(input logic [AW-1:0] b, input logic [AW-1:0] l, input logic [7:0] i);
      base = b; len = l; inc = i; run = 1'b1;
      step();
      run = 1'b0;
   endtask

   task automatic wait_idle(input int limit, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < limit; c++) begin
         if (!waitreq) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   typedef struct {
      logic [AW-1:0] base;
      logic [AW-1:0] len;
      logic [7:0]    inc;
      int            n;
      logic [BC-1:0] last_be;
      int            lat;
      bit            rd_st;
      bit            wr_st;
      bit            busy_run;
   } vec_t;

   vec_t vt[6];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int rq0, wq0, wl0;
      logic [AW-1:0] ea;
      logic [BC-1:0] eb;

      //          base     len     inc    n  last_be lat rd_st wr_st busy
      vt[0] = '{10'h010, 10'd20, 8'h01, 3, 8'h0F, 1, 1'b0, 1'b0, 1'b0};
      vt[1] = '{10'h100, 10'd6,  8'hFF, 1, 8'h3F, 1, 1'b0, 1'b0, 1'b0};
      vt[2] = '{10'h040, 10'd50, 8'h10, 7, 8'h03, 5, 1'b0, 1'b1, 1'b0};
      vt[3] = '{10'h3FE, 10'd32, 8'h80, 4, 8'hFF, 2, 1'b0, 1'b0, 1'b0};
      vt[4] = '{10'h200, 10'd10, 8'h05, 2, 8'h03, 2, 1'b1, 1'b0, 1'b1};
      vt[5] = '{10'h300, 10'd8,  8'h7F, 1, 8'hFF, 3, 1'b1, 1'b1, 1'b0};

      for (int a = 0; a < 1024; a++)
         for (int i = 0; i < BC; i++)
            mem[a][8*i +: 8] = 8'(a * 7 + i * 31 + 5);
      mem[10'h010] = 64'h0706_0504_0302_0100;
      mem[10'h012] = 64'hFFFF_FFFF_FFFF_FFFF;
      mem[10'h100] = 64'hAA55_0080_7F01_FF00;

      // reset state
      step();
      chk("reset waitreq", 64'(waitreq), 64'd0);
      chk("reset rd_read", 64'(rd_read), 64'd0);
      chk("reset wr_write", 64'(wr_write), 64'd0);
      chk("reset rd_addr", 64'(rd_addr), 64'd0);
      arst_n = 1'b1;
      step();
      step();

      // table-driven transfers
      for (int v = 0; v < 6; v++) begin
         rd_lat = vt[v].lat; rd_st = vt[v].rd_st; wr_st = vt[v].wr_st;
         rd_log.delete(); wr_log.delete(); max_outst = 0;
         start_op(vt[v].base, vt[v].len, vt[v].inc);
         chk($sformatf("v%0d busy", v), 64'(waitreq), 64'd1);
         if (vt[v].busy_run) begin
            step();
            base = 10'h055; len = 10'd100; inc = 8'h00; run = 1'b1;
            step();
            run = 1'b0;
         end
         wait_idle(2000, ok);
         chk($sformatf("v%0d done", v), 64'(ok), 64'd1);
         step(); step();
         chk($sformatf("v%0d reads", v), 64'(rd_log.size()), 64'(vt[v].n));
         chk($sformatf("v%0d writes", v), 64'(wr_log.size()), 64'(vt[v].n));
         chk($sformatf("v%0d outst<=depth", v), 64'(max_outst <= FD), 64'd1);
         for (int k = 0; k < vt[v].n; k++) begin
            ea = vt[v].base + 10'(k);
            eb = (k == vt[v].n - 1) ? vt[v].last_be : 8'hFF;
            if (k < rd_log.size())
               chk($sformatf("v%0d rd_addr[%0d]", v, k), 64'(rd_log[k]), 64'(ea));
            if (k < wr_log.size()) begin
               chk($sformatf("v%0d wr_addr[%0d]", v, k), 64'(wr_log[k].addr), 64'(ea));
               chk($sformatf("v%0d be[%0d]", v, k), 64'(wr_log[k].be), 64'(eb));
               chk($sformatf("v%0d data[%0d]", v, k), wr_log[k].data,
                   expect_data(mem[ea], eb, vt[v].inc));
            end
         end
         if (v == 0 && wr_log.size() == 3) begin
            chk("v0 hand data0", wr_log[0].data, 64'h0807_0605_0403_0201);
            chk("v0 hand data2", wr_log[2].data, 64'hFFFF_FFFF_0000_0000);
         end
         if (v == 1 && wr_log.size() == 1)
            chk("v1 hand data", wr_log[0].data, 64'hAA55_FF7F_7E00_FEFF);
      end

      // zero-length run is ignored
      rq0 = rd_req_cyc; wq0 = wr_req_cyc;
      start_op(10'h123, 10'd0, 8'h01);
      chk("len0 waitreq", 64'(waitreq), 64'd0);
      repeat (5) step();
      chk("len0 waitreq later", 64'(waitreq), 64'd0);
      chk("len0 no reads", 64'(rd_req_cyc - rq0), 64'd0);
      chk("len0 no writes", 64'(wr_req_cyc - wq0), 64'd0);

      // reset in the middle of a 64-byte transfer
      rd_lat = 5; rd_st = 1'b0; wr_st = 1'b1;
      rd_log.delete(); wr_log.delete();
      start_op(10'h080, 10'd64, 8'h01);
      repeat (8) step();
      chk("abort still busy", 64'(waitreq), 64'd1);
      arst_n = 1'b0;
      #1;
      chk("abort waitreq", 64'(waitreq), 64'd0);
      chk("abort rd_read", 64'(rd_read), 64'd0);
      chk("abort wr_write", 64'(wr_write), 64'd0);
      chk("abort wr_addr", 64'(wr_addr), 64'd0);
      chk("abort wr_data", wr_data, 64'd0);
      chk("abort wr_be", 64'(wr_be), 64'd0);
      wl0 = wr_log.size(); rq0 = rd_req_cyc; wq0 = wr_req_cyc;
      step();
      arst_n = 1'b1;
      repeat (12) step();
      chk("abort no later writes", 64'(wr_req_cyc - wq0), 64'd0);
      chk("abort write log", 64'(wr_log.size()), 64'(wl0));
      chk("abort no later reads", 64'(rd_req_cyc - rq0), 64'd0);
      chk("abort idle", 64'(waitreq), 64'd0);

      // first start is taken on the second edge after reset release
      arst_n = 1'b0;
      step();
      rd_lat = 1; wr_st = 1'b0;
      rd_log.delete(); wr_log.delete();
      base = 10'h020; len = 10'd8; inc = 8'h02; run = 1'b1;
      arst_n = 1'b1;
      step();
      chk("release edge1 waitreq", 64'(waitreq), 64'd0);
      step();
      chk("release edge2 waitreq", 64'(waitreq), 64'd1);
      run = 1'b0;
      wait_idle(500, ok);
      chk("release done", 64'(ok), 64'd1);
      step();
      chk("release writes", 64'(wr_log.size()), 64'd1);
      if (wr_log.size() == 1) begin
         chk("release wr_addr", 64'(wr_log[0].addr), 64'h020);
         chk("release data", wr_log[0].data, expect_data(mem[10'h020], 8'hFF, 8'h02));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
